// File: rtl/sim_pkg.sv
// Shared state encoding and helpers for the simulator run controller.
package sim_pkg;

    typedef enum logic [2:0] {
        SIM_INVALID     = 3'd0,
        SIM_INITIALIZED = 3'd1,
        SIM_WARMUP      = 3'd2,
        SIM_RUNNING     = 3'd3,
        SIM_PAUSED      = 3'd4,
        SIM_COMPLETED   = 3'd5
    } sim_state_e;

    function automatic logic is_tick_state(input sim_state_e s);
        return (s == SIM_WARMUP) || (s == SIM_RUNNING);
    endfunction

endpackage

// File: rtl/sim_cycle_counter.sv
// Cycle counter with synchronous clear (priority) and count enable.
module sim_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/sim_run_controller.sv
// Run-lifecycle FSM for the cycle-level simulator: sequences warmup/measure phases,
// emits the per-cycle tick and tracks total/measured cycles against latched limits.
module sim_run_controller
    import sim_pkg::*;
#(
    parameter int CYCLE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   resume,
    input  logic                   abort,
    input  logic                   clear,
    input  logic [CYCLE_WIDTH-1:0] cfg_max_cycle,
    input  logic [CYCLE_WIDTH-1:0] cfg_warmup_cycles,
    output sim_state_e             state,
    output logic                   sim_tick,
    output logic [CYCLE_WIDTH-1:0] current_cycle,
    output logic [CYCLE_WIDTH-1:0] measured_cycle,
    output logic                   done,
    output logic                   aborted
);

    sim_state_e             r_state;
    sim_state_e             w_nxt;
    logic [CYCLE_WIDTH-1:0] r_max;
    logic [CYCLE_WIDTH-1:0] r_warm;
    logic                   r_tick;
    logic                   r_done;
    logic                   r_aborted;
    logic                   r_phase_run;
    logic [CYCLE_WIDTH-1:0] w_cur;
    logic [CYCLE_WIDTH-1:0] w_meas;
    logic [CYCLE_WIDTH-1:0] w_cur_inc;
    logic                   w_in_tick;
    logic                   w_cnt_clr;

    assign w_in_tick = is_tick_state(r_state);
    // cur never reaches max while ticking, so cur+1 cannot wrap even for max = all-ones
    assign w_cur_inc = w_cur + CYCLE_WIDTH'(1);
    assign w_cnt_clr = (r_state == SIM_COMPLETED) && clear;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            SIM_INVALID:     w_nxt = SIM_INITIALIZED;
            SIM_INITIALIZED: begin
                if (start) begin
                    if (cfg_max_cycle == '0)
                        w_nxt = SIM_COMPLETED;
                    else if (cfg_warmup_cycles != '0)
                        w_nxt = SIM_WARMUP;
                    else
                        w_nxt = SIM_RUNNING;
                end
            end
            SIM_WARMUP, SIM_RUNNING: begin
                if (abort)
                    w_nxt = SIM_COMPLETED;
                else if (w_cur_inc == r_max)
                    w_nxt = SIM_COMPLETED;
                else if (pause)
                    w_nxt = SIM_PAUSED;
                else if (r_state == SIM_WARMUP && w_cur_inc == r_warm)
                    w_nxt = SIM_RUNNING;
            end
            SIM_PAUSED: begin
                if (abort)
                    w_nxt = SIM_COMPLETED;
                else if (resume)
                    w_nxt = r_phase_run ? SIM_RUNNING : SIM_WARMUP;
            end
            SIM_COMPLETED: begin
                if (clear)
                    w_nxt = SIM_INITIALIZED;
            end
            default:         w_nxt = SIM_INVALID;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SIM_INVALID;
            r_max       <= '0;
            r_warm      <= '0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_phase_run <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_tick  <= is_tick_state(w_nxt);
            r_done  <= (w_nxt == SIM_COMPLETED) && (r_state != SIM_COMPLETED);
            if (r_state == SIM_INITIALIZED && start) begin
                r_max  <= cfg_max_cycle;
                r_warm <= cfg_warmup_cycles;
            end
            // Pausing on the last warmup tick must resume into RUNNING, not WARMUP
            if (w_in_tick && w_nxt == SIM_PAUSED)
                r_phase_run <= (r_state == SIM_RUNNING) || (w_cur_inc == r_warm);
            if ((w_in_tick || r_state == SIM_PAUSED) && abort)
                r_aborted <= 1'b1;
            if (w_cnt_clr) begin
                r_aborted <= 1'b0;
                r_max     <= '0;
                r_warm    <= '0;
            end
        end
    end

    sim_cycle_counter #(.WIDTH(CYCLE_WIDTH)) u_cur_cnt (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_in_tick),
        .o_count (w_cur)
    );

    sim_cycle_counter #(.WIDTH(CYCLE_WIDTH)) u_meas_cnt (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (r_state == SIM_RUNNING),
        .o_count (w_meas)
    );

    assign state          = r_state;
    assign sim_tick       = r_tick;
    assign current_cycle  = w_cur;
    assign measured_cycle = w_meas;
    assign done           = r_done;
    assign aborted        = r_aborted;

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: vector table, directed corner sequences, and
// randomized traffic against an arithmetic lifecycle model.
module tb_sim_run_controller;
    import sim_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0, clear = 1'b0;
    logic [W-1:0] cfg_max_cycle = '0, cfg_warmup_cycles = '0;
    sim_state_e   state;
    logic         sim_tick, done, aborted;
    logic [W-1:0] current_cycle, measured_cycle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sim_run_controller #(.CYCLE_WIDTH(W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .pause             (pause),
        .resume            (resume),
        .abort             (abort),
        .clear             (clear),
        .cfg_max_cycle     (cfg_max_cycle),
        .cfg_warmup_cycles (cfg_warmup_cycles),
        .state             (state),
        .sim_tick          (sim_tick),
        .current_cycle     (current_cycle),
        .measured_cycle    (measured_cycle),
        .done              (done),
        .aborted           (aborted)
    );

    task automatic chk(input string nm, input sim_state_e es, input logic et,
                       input logic [W-1:0] ec, input logic [W-1:0] em,
                       input logic ed, input logic ea);
        total++;
        if (state !== es || sim_tick !== et || current_cycle !== ec ||
            measured_cycle !== em || done !== ed || aborted !== ea) begin
            bad++;
            $display("FAIL %s: got st=%0d tick=%0b cur=%0d meas=%0d done=%0b ab=%0b want st=%0d tick=%0b cur=%0d meas=%0d done=%0b ab=%0b",
                     nm, state, sim_tick, current_cycle, measured_cycle, done, aborted,
                     es, et, ec, em, ed, ea);
        end
    endtask

    // Called at a negedge: drive inputs, take one rising edge, return at the next negedge.
    task automatic step(input logic st, input logic pa, input logic re,
                        input logic ab, input logic cl);
        start = st; pause = pa; resume = re; abort = ab; clear = cl;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Phase is derived from cur vs warmup; measured = ticks past warmup.
    typedef enum int {M_INV, M_INIT, M_ACT, M_PAU, M_DONE} mmode_e;
    mmode_e      m_mode;
    int unsigned m_cur, m_max, m_warm;
    logic        m_first, m_ab;

    function automatic void model_reset();
        m_mode = M_INV; m_cur = 0; m_max = 0; m_warm = 0; m_first = 1'b0; m_ab = 1'b0;
    endfunction

    function automatic void model_step(input logic st, input logic pa, input logic re,
                                       input logic ab, input logic cl,
                                       input int unsigned mx, input int unsigned wm);
        m_first = 1'b0;
        case (m_mode)
            M_INV:  m_mode = M_INIT;
            M_INIT: if (st) begin
                m_max = mx; m_warm = wm;
                if (mx == 0) begin m_mode = M_DONE; m_first = 1'b1; end
                else m_mode = M_ACT;
            end
            M_ACT: begin
                m_cur++;
                if (ab) begin m_mode = M_DONE; m_ab = 1'b1; m_first = 1'b1; end
                else if (m_cur == m_max) begin m_mode = M_DONE; m_first = 1'b1; end
                else if (pa) m_mode = M_PAU;
            end
            M_PAU: begin
                if (ab) begin m_mode = M_DONE; m_ab = 1'b1; m_first = 1'b1; end
                else if (re) m_mode = M_ACT;
            end
            M_DONE: if (cl) begin m_mode = M_INIT; m_cur = 0; m_ab = 1'b0; end
            default: m_mode = M_INV;
        endcase
    endfunction

    function automatic sim_state_e m_state();
        sim_state_e s;
        s = SIM_INVALID;
        case (m_mode)
            M_INIT: s = SIM_INITIALIZED;
            M_ACT:  s = (m_cur < m_warm) ? SIM_WARMUP : SIM_RUNNING;
            M_PAU:  s = SIM_PAUSED;
            M_DONE: s = SIM_COMPLETED;
            default: s = SIM_INVALID;
        endcase
        return s;
    endfunction

    function automatic int unsigned m_meas();
        return (m_cur > m_warm) ? m_cur - m_warm : 0;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic st, pa, re, ab, cl;
        int unsigned mx, wm;
        sim_state_e es;
        logic et;
        int unsigned ec, em;
        logic ed, ea;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic st, input logic pa, input logic re, input logic ab,
                                input logic cl, input int unsigned mx, input int unsigned wm,
                                input sim_state_e es, input logic et, input int unsigned ec,
                                input int unsigned em, input logic ed, input logic ea);
        vec_t v;
        v.st = st; v.pa = pa; v.re = re; v.ab = ab; v.cl = cl; v.mx = mx; v.wm = wm;
        v.es = es; v.et = et; v.ec = ec; v.em = em; v.ed = ed; v.ea = ea;
        vq.push_back(v);
    endfunction

    initial begin
        // max=5 warmup=2: 2 WARMUP + 3 RUNNING ticks
        add(0,0,0,0,0, 5,2, SIM_INITIALIZED,0, 0,0, 0,0);
        add(1,0,0,0,0, 5,2, SIM_WARMUP,     1, 0,0, 0,0);
        add(0,0,0,0,0, 5,2, SIM_WARMUP,     1, 1,0, 0,0);
        add(0,0,0,0,0, 5,2, SIM_RUNNING,    1, 2,0, 0,0);
        add(0,0,0,0,0, 5,2, SIM_RUNNING,    1, 3,1, 0,0);
        add(0,0,0,0,0, 5,2, SIM_RUNNING,    1, 4,2, 0,0);
        add(0,0,0,0,0, 5,2, SIM_COMPLETED,  0, 5,3, 1,0);
        add(1,1,1,0,0, 5,2, SIM_COMPLETED,  0, 5,3, 0,0);
        add(0,0,0,0,1, 5,2, SIM_INITIALIZED,0, 0,0, 0,0);
        // max=4 warmup=0: straight to RUNNING
        add(1,0,0,0,0, 4,0, SIM_RUNNING,    1, 0,0, 0,0);
        add(0,0,0,0,0, 4,0, SIM_RUNNING,    1, 1,1, 0,0);
        add(0,0,0,0,0, 4,0, SIM_RUNNING,    1, 2,2, 0,0);
        add(0,0,0,0,0, 4,0, SIM_RUNNING,    1, 3,3, 0,0);
        add(0,0,0,0,0, 4,0, SIM_COMPLETED,  0, 4,4, 1,0);
        add(0,0,0,0,1, 4,0, SIM_INITIALIZED,0, 0,0, 0,0);
        // max=0: immediate completion
        add(1,0,0,0,0, 0,3, SIM_COMPLETED,  0, 0,0, 1,0);
        add(0,0,0,0,1, 0,3, SIM_INITIALIZED,0, 0,0, 0,0);
        // max=3 warmup=8: finishes inside WARMUP
        add(1,0,0,0,0, 3,8, SIM_WARMUP,     1, 0,0, 0,0);
        add(0,0,0,0,0, 3,8, SIM_WARMUP,     1, 1,0, 0,0);
        add(0,0,0,0,0, 3,8, SIM_WARMUP,     1, 2,0, 0,0);
        add(0,0,0,0,0, 3,8, SIM_COMPLETED,  0, 3,0, 1,0);
        add(0,0,0,0,1, 3,8, SIM_INITIALIZED,0, 0,0, 0,0);

        @(negedge clk);
        chk("reset", SIM_INVALID, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            cfg_max_cycle = W'(vq[i].mx); cfg_warmup_cycles = W'(vq[i].wm);
            step(vq[i].st, vq[i].pa, vq[i].re, vq[i].ab, vq[i].cl);
            chk($sformatf("vec%0d", i), vq[i].es, vq[i].et, W'(vq[i].ec), W'(vq[i].em),
                vq[i].ed, vq[i].ea);
        end

        // pause mid-RUNNING, freeze, then pause+resume together
        cfg_max_cycle = 10; cfg_warmup_cycles = 0;
        step(1,0,0,0,0); chk("A_start", SIM_RUNNING, 1, 0, 0, 0, 0);
        repeat (3) step(0,0,0,0,0);
        chk("A_cur3", SIM_RUNNING, 1, 3, 3, 0, 0);
        step(0,1,0,0,0); chk("A_pause", SIM_PAUSED, 0, 4, 4, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0,0,0,0,0); chk("A_frozen", SIM_PAUSED, 0, 4, 4, 0, 0);
        end
        step(0,1,1,0,0); chk("A_resume", SIM_RUNNING, 1, 4, 4, 0, 0);
        for (int k = 0; k < 20 && state != SIM_COMPLETED; k++) step(0,0,0,0,0);
        chk("A_end", SIM_COMPLETED, 0, 10, 10, 1, 0);
        step(0,0,0,0,1);

        // pause in WARMUP, resume returns to WARMUP
        cfg_max_cycle = 10; cfg_warmup_cycles = 3;
        step(1,0,0,0,0); step(0,0,0,0,0);
        chk("B_warm1", SIM_WARMUP, 1, 1, 0, 0, 0);
        step(0,1,0,0,0); chk("B_pause", SIM_PAUSED, 0, 2, 0, 0, 0);
        step(0,0,0,0,0); step(0,0,1,0,0);
        chk("B_resume", SIM_WARMUP, 1, 2, 0, 0, 0);
        for (int k = 0; k < 20 && state != SIM_COMPLETED; k++) step(0,0,0,0,0);
        chk("B_end", SIM_COMPLETED, 0, 10, 7, 1, 0);
        step(0,0,0,0,1);

        // abort while PAUSED beats resume; later inputs ignored; clear wipes all
        cfg_max_cycle = 10; cfg_warmup_cycles = 0;
        step(1,0,0,0,0); step(0,1,0,0,0);
        chk("C_pause", SIM_PAUSED, 0, 1, 1, 0, 0);
        step(0,0,1,1,0); chk("C_abort", SIM_COMPLETED, 0, 1, 1, 1, 1);
        step(1,1,1,0,0); chk("C_hold", SIM_COMPLETED, 0, 1, 1, 0, 1);
        step(0,0,0,0,1); chk("C_clear", SIM_INITIALIZED, 0, 0, 0, 0, 0);

        // asynchronous reset mid-run
        cfg_max_cycle = 10; cfg_warmup_cycles = 2;
        step(1,0,0,0,0); step(0,0,0,0,0); step(0,0,0,0,0);
        chk("D_run", SIM_RUNNING, 1, 2, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 chk("D_reset", SIM_INVALID, 0, 0, 0, 0, 0);
        @(negedge clk); reset_n = 1'b1;
        step(0,0,0,0,0); chk("D_init", SIM_INITIALIZED, 0, 0, 0, 0, 0);

        // randomized traffic against the model
        reset_n = 1'b0;
        #1 model_reset();
        chk("R_reset", m_state(), 1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic st, pa, re, ab, cl;
            int unsigned mx, wm;
            if ($urandom_range(299) == 0) begin
                reset_n = 1'b0;
                #1 model_reset();
                chk("R_async_rst", m_state(), 1'b0, 0, 0, 1'b0, 1'b0);
                @(negedge clk); reset_n = 1'b1;
            end
            st = ($urandom_range(3) == 0);
            pa = ($urandom_range(7) == 0);
            re = ($urandom_range(2) == 0);
            ab = ($urandom_range(24) == 0);
            cl = ($urandom_range(3) == 0);
            mx = ($urandom_range(9) == 0) ? 0 : $urandom_range(12, 1);
            wm = $urandom_range(14);
            cfg_max_cycle = W'(mx); cfg_warmup_cycles = W'(wm);
            step(st, pa, re, ab, cl);
            model_step(st, pa, re, ab, cl, mx, wm);
            chk("rand", m_state(), (m_mode == M_ACT), W'(m_cur), W'(m_meas()), m_first, m_ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
